// File: rtl/instruction_encoder.sv
// instruction_encoder: turns op/register/immediate tuples into RV32IM-subset
// instruction words and streams them, each tagged with a word-aligned program
// address, over a valid/ready handshake. Rejected requests halt the encoder
// until clear_error.
module instruction_encoder #(
   parameter int DATA_WIDTH        = 32,
   parameter int REGADDR_WIDTH     = 5,
   parameter int INSTRUCTION_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [4:0]                   in_op,
   input  logic [REGADDR_WIDTH-1:0]     in_rd,
   input  logic [REGADDR_WIDTH-1:0]     in_rs1,
   input  logic [REGADDR_WIDTH-1:0]     in_rs2,
   input  logic [DATA_WIDTH-1:0]        in_imm,
   input  logic                         load_address,
   input  logic [DATA_WIDTH-1:0]        address_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
   output logic [DATA_WIDTH-1:0]        out_address,
   output logic                         error,
   output logic [1:0]                   error_code,
   input  logic                         clear_error,
   output logic [7:0]                   error_count
);

   typedef enum logic { S_RUN, S_HALTED } state_t;
   typedef enum logic [1:0] { F_R, F_I, F_B, F_J } fmt_t;

   state_t                         r_state, w_state_nxt;
   logic   [DATA_WIDTH-1:0]        r_addr;
   fmt_t                           w_fmt;
   logic                           w_illegal;
   logic   [2:0]                   w_f3;
   logic   [6:0]                   w_f7;
   logic                           w_range_bad;
   logic   [1:0]                   w_err_code;
   logic   [INSTRUCTION_WIDTH-1:0] w_word;
   logic                           w_accept, w_good, w_bad;
   logic   [DATA_WIDTH-1:0]        w_load_addr, w_tag_addr;

   // Op decode: instruction format, funct3/funct7, legality
   always_comb begin
      w_fmt     = F_R;
      w_f3      = 3'd0;
      w_f7      = 7'h00;
      w_illegal = 1'b0;
      case (in_op)
         5'd0:  begin w_fmt = F_I; w_f3 = 3'd0; end
         5'd1:  begin w_fmt = F_R; w_f3 = 3'd0; w_f7 = 7'h00; end
         5'd2:  begin w_fmt = F_R; w_f3 = 3'd0; w_f7 = 7'h20; end
         5'd3:  begin w_fmt = F_R; w_f3 = 3'd0; w_f7 = 7'h01; end
         5'd4:  begin w_fmt = F_R; w_f3 = 3'd4; w_f7 = 7'h01; end
         5'd5:  begin w_fmt = F_R; w_f3 = 3'd5; w_f7 = 7'h01; end
         5'd6:  begin w_fmt = F_R; w_f3 = 3'd6; w_f7 = 7'h01; end
         5'd7:  begin w_fmt = F_R; w_f3 = 3'd7; w_f7 = 7'h01; end
         5'd8:  begin w_fmt = F_I; w_f3 = 3'd2; end
         5'd9:  begin w_fmt = F_I; w_f3 = 3'd3; end
         5'd10: begin w_fmt = F_R; w_f3 = 3'd2; w_f7 = 7'h00; end
         5'd11: begin w_fmt = F_R; w_f3 = 3'd3; w_f7 = 7'h00; end
         5'd12: begin w_fmt = F_J; end
         5'd13: begin w_fmt = F_B; w_f3 = 3'd0; end
         5'd14: begin w_fmt = F_B; w_f3 = 3'd1; end
         5'd15: begin w_fmt = F_B; w_f3 = 3'd4; end
         5'd16: begin w_fmt = F_B; w_f3 = 3'd5; end
         5'd17: begin w_fmt = F_B; w_f3 = 3'd6; end
         5'd18: begin w_fmt = F_B; w_f3 = 3'd7; end
         default: w_illegal = 1'b1;
      endcase
   end

   // Immediate range check and prioritised error code (illegal > range > odd offset)
   always_comb begin
      w_range_bad = 1'b0;
      case (w_fmt)
         F_I: w_range_bad = ($signed(in_imm) < -2048) || ($signed(in_imm) > 2047);
         F_B: w_range_bad = ($signed(in_imm) < -4096) || ($signed(in_imm) > 4094);
         F_J: w_range_bad = ($signed(in_imm) < -(1 <<< 20)) || ($signed(in_imm) > (1 <<< 20) - 2);
         default: w_range_bad = 1'b0;
      endcase
      if (w_illegal)                                     w_err_code = 2'd1;
      else if (w_range_bad)                              w_err_code = 2'd2;
      else if ((w_fmt == F_B || w_fmt == F_J) && in_imm[0]) w_err_code = 2'd3;
      else                                               w_err_code = 2'd0;
   end

   // Word assembly per format
   always_comb begin
      case (w_fmt)
         F_I:     w_word = {in_imm[11:0], in_rs1, w_f3, in_rd, 7'h13};
         F_B:     w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                            in_imm[4:1], in_imm[11], 7'h63};
         F_J:     w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'h6F};
         default: w_word = {w_f7, in_rs2, in_rs1, w_f3, in_rd, 7'h33};
      endcase
   end

   assign in_ready    = (r_state == S_RUN) && (!out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_good      = w_accept && (w_err_code == 2'd0);
   assign w_bad       = w_accept && (w_err_code != 2'd0);
   assign w_load_addr = {address_in[DATA_WIDTH-1:2], 2'b00};
   assign w_tag_addr  = load_address ? w_load_addr : r_addr;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_RUN;
      else       r_state <= w_state_nxt;
   end

   // Next state: halt on a rejected accept, resume on clear_error
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:    if (w_bad)       w_state_nxt = S_HALTED;
         S_HALTED: if (clear_error) w_state_nxt = S_RUN;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   // Address counter: load has priority, good accepts advance past the tagged word
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_addr <= '0;
      else if (w_good) r_addr <= w_tag_addr + DATA_WIDTH'(4);
      else if (load_address) r_addr <= w_load_addr;
   end

   // Output register: reload on good accept, otherwise drain on pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_address     <= '0;
      end else if (w_good) begin
         out_valid       <= 1'b1;
         out_instruction <= w_word;
         out_address     <= w_tag_addr;
      end else if (out_ready) begin
         out_valid       <= 1'b0;
      end
   end

   // Sticky error flag/code and saturating reject counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error       <= 1'b0;
         error_code  <= 2'd0;
         error_count <= 8'd0;
      end else if (w_bad) begin
         error       <= 1'b1;
         error_code  <= w_err_code;
         if (error_count != 8'hFF) error_count <= error_count + 8'd1;
      end else if (clear_error) begin
         error       <= 1'b0;
         error_code  <= 2'd0;
      end
   end

endmodule
